// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath: width defaults, drain FSM states,
// gemm_uno modes and the accumulator-to-output conversion helper.
package pe_pkg;

    localparam int INT_BW_DEF = 5;
    localparam int FRA_BW_DEF = 10;
    localparam int MUL_BW_DEF = 16;
    localparam int ACC_BW_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } drain_state_e;

    typedef enum logic [1:0] {
        MODE_GEMM,
        MODE_DIV,
        MODE_EXP,
        MODE_LOG
    } gemm_mode_e;

    typedef struct packed {
        logic        sat;
        logic [63:0] word;
    } conv_res_t;

    // Works on a 64-bit sign-extended accumulator so no intermediate can wrap;
    // the caller keeps the low MUL_BW bits of word.
    function automatic conv_res_t pe_conv(input logic signed [63:0] val,
                                          input int                 int_bw,
                                          input int                 fra_bw,
                                          input logic               rnd_en);
        conv_res_t          r;
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = rnd_en ? (val + (64'sd1 <<< (fra_bw - 1))) : val;
        hi = (64'sd1 <<< (int_bw + 2 * fra_bw)) - 64'sd1;
        lo = -(64'sd1 <<< (int_bw + 2 * fra_bw));
        if (v > hi) begin
            r.sat  = 1'b1;
            r.word = (64'sd1 <<< (int_bw + fra_bw)) - 64'sd1;
        end else if (v < lo) begin
            r.sat  = 1'b1;
            r.word = -(64'sd1 <<< (int_bw + fra_bw));
        end else begin
            r.sat  = 1'b0;
            r.word = v >>> fra_bw;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Single-clock FIFO with registered storage; head word is visible the cycle
// after it is written and reads as zero while empty.
module pe_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q;
    logic [ADDR_W:0]  rd_ptr_q;
    logic [ADDR_W:0]  wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: rtl/pe_drain.sv
// Drains a counted job of PE accumulator results into a saturated Q-format
// output stream. Define PE_DRAIN_RND_EN for round-half-up instead of truncation.
module pe_drain
    import pe_pkg::*;
#(
    parameter int INT_BW = INT_BW_DEF,
    parameter int FRA_BW = FRA_BW_DEF,
    parameter int MUL_BW = MUL_BW_DEF,
    parameter int ACC_BW = ACC_BW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [15:0]       len_i,
    input  logic [ACC_BW-1:0] res_i,
    input  logic              res_vld_i,
    output logic              res_rdy_o,
    output logic [MUL_BW-1:0] out_data_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o
);

`ifdef PE_DRAIN_RND_EN
    localparam logic RND_EN = 1'b1;
`else
    localparam logic RND_EN = 1'b0;
`endif

    drain_state_e      state_q;
    logic [15:0]       rem_q;
    logic              sat_q;
    logic              busy_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic [63:0]       res_ext;
    conv_res_t         conv;
    logic [MUL_BW-1:0] conv_word;
    logic              unused_conv_hi;

    assign res_ext        = 64'($signed(res_i));
    assign conv           = pe_conv(res_ext, INT_BW, FRA_BW, RND_EN);
    assign conv_word      = conv.word[MUL_BW-1:0];
    assign unused_conv_hi = ^conv.word[63:MUL_BW];

    // No full-FIFO bypass: a pop in the same cycle does not reopen the input.
    assign res_rdy_o = (state_q == ST_RUN) && !fifo_full && (rem_q != 16'd0);
    assign accept    = res_vld_i && res_rdy_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_q <= len_i;
                        sat_q <= 1'b0;
                        if (len_i != 16'd0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        rem_q <= rem_q - 16'd1;
                        if (conv.sat) begin
                            sat_q <= 1'b1;
                        end
                    end
                    if ((rem_q == 16'd0) && fifo_empty) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    pe_sync_fifo #(
        .WIDTH (MUL_BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .wdata_i (conv_word),
        .pop_i   (out_rdy_i),
        .rdata_o (out_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_vld_o = !fifo_empty;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_pe_drain.sv
// Scoreboard bench for pe_drain: accepted words are modelled into a queue and
// checked in order as the output handshake completes.
module tb_pe_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] len_i;
    logic [31:0] res_i;
    logic        res_vld_i;
    logic        res_rdy_o;
    logic [15:0] out_data_o;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic        busy_o;
    logic        done_o;
    logic        sat_o;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          done_cnt     = 0;
    int          acc_cnt      = 0;
    int          pop_cnt      = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    always #5 clk = ~clk;

    pe_drain dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .res_i      (res_i),
        .res_vld_i  (res_vld_i),
        .res_rdy_o  (res_rdy_o),
        .out_data_o (out_data_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sat_o      (sat_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [31:0] r);
        longint v;
        v = longint'($signed(r));
`ifdef PE_DRAIN_RND_EN
        v = v + 64'sd512;
`endif
        if (v > 64'sd33554431) return 16'h7FFF;
        if (v < -64'sd33554432) return 16'h8000;
        v = v >>> 10;
        return v[15:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) done_cnt++;
            if (res_vld_i && res_rdy_o) begin
                exp_q.push_back(model(res_i));
                acc_cnt++;
            end
            if (out_vld_o && out_rdy_i) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("sb_data", 32'(out_data_o), 32'(mon_exp));
                    $display("[TB] word 0x%04h (expected 0x%04h)", out_data_o, mon_exp);
                end
            end
        end
    end

    task automatic start_job(input logic [15:0] len);
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = len;
        @(posedge clk); #1;
        start_i = 1'b0;
        $display("[TB] start len=%0d", len);
    endtask

    task automatic drive_word(input logic [31:0] v);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        @(posedge clk); #1;
        res_vld_i = 1'b1;
        res_i     = v;
        while (!got && n < 64) begin
            @(negedge clk);
            got = res_rdy_o;
            @(posedge clk); #1;
            n++;
        end
        res_vld_i = 1'b0;
        chk("accept", 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_rdy"}, 32'(res_rdy_o), 32'd0);
        chk({tag, "_out_vld"}, 32'(out_vld_o), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_sat"}, 32'(sat_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [12];
        int          a0;
        int          p0;
        int          d0;

        rst = 1'b1; start_i = 1'b0; len_i = '0; res_i = '0;
        res_vld_i = 1'b0; out_rdy_i = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Single word: latency and done after the pop.
        start_job(16'd1);
        @(negedge clk);
        chk("busy_run", 32'(busy_o), 32'd1);
        drive_word(32'h0010_0000);
        @(negedge clk);
        chk("lat_vld", 32'(out_vld_o), 32'd1);
        chk("lat_data", 32'(out_data_o), 32'h0400);
        wait_done("done_single");
        chk("idle_vld", 32'(out_vld_o), 32'd0);

        // Positive and negative saturation, sticky flag.
        start_job(16'd2);
        drive_word(32'h0400_0000);
        drive_word(32'hFC00_0000);
        wait_done("done_sat");
        chk("sat_sticky", 32'(sat_o), 32'd1);

        // Zero-length job: done two cycles after start, flag cleared.
        d0 = done_cnt;
        start_job(16'd0);
        @(negedge clk);
        chk("len0_done_early", 32'(done_o), 32'd0);
        chk("len0_sat_clr", 32'(sat_o), 32'd0);
        chk("len0_res_rdy", 32'(res_rdy_o), 32'd0);
        @(negedge clk);
        chk("len0_done", 32'(done_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("len0_single_done", 32'(done_cnt - d0), 32'd1);

        // Rounding threshold case.
        start_job(16'd1);
        drive_word(32'h0000_0200);
        wait_done("done_rnd");
        chk("rnd_sat", 32'(sat_o), 32'd0);

        // Backpressure: FIFO fills at 8, then drains 12 words in order.
        vals[0] = 32'h0010_0000;
        for (int i = 1; i < 12; i++) vals[i] = 32'($signed($urandom()) >>> 6);
        out_rdy_i = 1'b0;
        a0 = acc_cnt;
        p0 = pop_cnt;
        start_job(16'd12);
        for (int i = 0; i < 8; i++) drive_word(vals[i]);
        @(posedge clk); #1;
        res_vld_i = 1'b1;
        res_i     = vals[8];
        repeat (4) begin
            @(negedge clk);
            chk("full_res_rdy", 32'(res_rdy_o), 32'd0);
        end
        chk("full_acc_cnt", 32'(acc_cnt - a0), 32'd8);
        chk("hold_vld", 32'(out_vld_o), 32'd1);
        chk("hold_data", 32'(out_data_o), 32'(exp_q[0]));
        @(posedge clk); #1;
        out_rdy_i = 1'b1;
        @(negedge clk);
        chk("no_bypass", 32'(res_rdy_o), 32'd0);
        for (int i = 8; i < 12; i++) drive_word(vals[i]);
        wait_done("done_bp");
        chk("bp_pops", 32'(pop_cnt - p0), 32'd12);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a job.
        out_rdy_i = 1'b0;
        start_job(16'd5);
        for (int i = 0; i < 3; i++) drive_word(32'($signed($urandom()) >>> 8));
        d0 = done_cnt;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        out_rdy_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_vld", 32'(out_vld_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
